// File: rtl/sr_cmd_gen_pkg.sv
// Shared FSM encoding and parameter defaults for the SR command generator.
package sr_cmd_pkg;

  localparam int unsigned DB_CYCLES_DEF = 4;
  localparam int unsigned HOLDOFF_DEF   = 8;
  localparam int unsigned CNT_W_DEF     = 8;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_PULSE_S = 2'd1,
    ST_PULSE_R = 2'd2,
    ST_HOLDOFF = 2'd3
  } state_e;

endpackage

// File: rtl/sr_cmd_gen_if.sv
// Request/response bundle between a request source and the SR command generator.
interface sr_cmd_gen_if;
  logic set_req;
  logic rst_req;
  logic s;
  logic r;
  logic q_pred;
  logic busy;
  logic drop;

  modport master (output set_req, rst_req, input s, r, q_pred, busy, drop);
  modport slave  (input set_req, rst_req, output s, r, q_pred, busy, drop);
endinterface

// File: rtl/sr_cmd_gen_debounce.sv
// Per-channel synchroniser, optional debounce filter and registered rising-edge event.
// Filter is present only when SR_CMD_DEBOUNCE_EN is defined.
module sr_debounce
  import sr_cmd_pkg::*;
#(
  parameter int unsigned DB_CYCLES = DB_CYCLES_DEF,
  parameter int unsigned CNT_W     = CNT_W_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic i_req,
  output logic o_evt
);

  logic r_sync1;
  logic r_sync2;
  logic r_filt_d;
  logic r_evt;
  logic w_filt;

  if ((64'(DB_CYCLES) < 64'(1)) || (64'(DB_CYCLES) >= (64'(1) << CNT_W))) begin : g_bad_db
    $error("sr_debounce: DB_CYCLES outside 1..2^CNT_W-1");
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
    end else begin
      r_sync1 <= i_req;
      r_sync2 <= r_sync1;
    end
  end

`ifdef SR_CMD_DEBOUNCE_EN
  logic             r_filt;
  logic [CNT_W-1:0] r_cnt;

  // Filtered level follows only after DB_CYCLES consecutive disagreeing samples.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_filt <= 1'b0;
      r_cnt  <= '0;
    end else if (r_sync2 == r_filt) begin
      r_cnt <= '0;
    end else if (r_cnt == CNT_W'(DB_CYCLES - 1)) begin
      r_filt <= r_sync2;
      r_cnt  <= '0;
    end else begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  assign w_filt = r_filt;
`else
  assign w_filt = r_sync2;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_filt_d <= 1'b0;
      r_evt    <= 1'b0;
    end else begin
      r_filt_d <= w_filt;
      r_evt    <= w_filt & ~r_filt_d;
    end
  end

  assign o_evt = r_evt;

endmodule

// File: rtl/sr_cmd_gen.sv
// SR command generator: mutually exclusive one-cycle s/r pulses with holdoff and q shadow.
// Debounce filtering is compiled in with SR_CMD_DEBOUNCE_EN.
module sr_cmd_gen
  import sr_cmd_pkg::*;
#(
  parameter int unsigned DB_CYCLES = DB_CYCLES_DEF,
  parameter int unsigned HOLDOFF   = HOLDOFF_DEF,
  parameter int unsigned CNT_W     = CNT_W_DEF
) (
  input logic         clk,
  input logic         rst,
  sr_cmd_gen_if.slave bus
);

  logic             w_set_evt;
  logic             w_rst_evt;
  state_e           r_state;
  logic [CNT_W-1:0] r_hold_cnt;
  logic             r_s;
  logic             r_r;
  logic             r_q;
  logic             r_busy;
  logic             r_drop;

  if ((64'(HOLDOFF) < 64'(1)) || (64'(HOLDOFF) >= (64'(1) << CNT_W))) begin : g_bad_holdoff
    $error("sr_cmd_gen: HOLDOFF outside 1..2^CNT_W-1");
  end

  sr_debounce #(.DB_CYCLES(DB_CYCLES), .CNT_W(CNT_W)) u_db_set (
    .clk   (clk),
    .rst   (rst),
    .i_req (bus.set_req),
    .o_evt (w_set_evt)
  );

  sr_debounce #(.DB_CYCLES(DB_CYCLES), .CNT_W(CNT_W)) u_db_rst (
    .clk   (clk),
    .rst   (rst),
    .i_req (bus.rst_req),
    .o_evt (w_rst_evt)
  );

  // Reset request wins a tie; any event outside IDLE is discarded and flagged.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= ST_IDLE;
      r_hold_cnt <= '0;
      r_s        <= 1'b0;
      r_r        <= 1'b0;
      r_q        <= 1'b1;
      r_busy     <= 1'b0;
      r_drop     <= 1'b0;
    end else begin
      r_s    <= 1'b0;
      r_r    <= 1'b0;
      r_drop <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_rst_evt) begin
            r_state <= ST_PULSE_R;
            r_r     <= 1'b1;
            r_busy  <= 1'b1;
            r_drop  <= w_set_evt;
          end else if (w_set_evt) begin
            r_state <= ST_PULSE_S;
            r_s     <= 1'b1;
            r_busy  <= 1'b1;
          end
        end
        ST_PULSE_S, ST_PULSE_R: begin
          r_q        <= (r_state == ST_PULSE_S);
          r_state    <= ST_HOLDOFF;
          r_hold_cnt <= CNT_W'(HOLDOFF - 1);
          r_drop     <= w_set_evt | w_rst_evt;
        end
        ST_HOLDOFF: begin
          r_drop <= w_set_evt | w_rst_evt;
          if (r_hold_cnt == '0) begin
            r_state <= ST_IDLE;
            r_busy  <= 1'b0;
          end else begin
            r_hold_cnt <= r_hold_cnt - CNT_W'(1);
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign bus.s      = r_s;
  assign bus.r      = r_r;
  assign bus.q_pred = r_q;
  assign bus.busy   = r_busy;
  assign bus.drop   = r_drop;

endmodule

// File: tb/tb_sr_cmd_gen.sv
// Randomised and directed bench for sr_cmd_gen against an edge-indexed behavioural model.
module tb_sr_cmd_gen;

  localparam int DB_CFG = 4;
  localparam int H      = 8;
`ifdef SR_CMD_DEBOUNCE_EN
  localparam int DB = DB_CFG;
`else
  localparam int DB = 0;
`endif
  localparam int LAT  = 3 + DB;
  localparam int MAXE = 4095;

  logic clk = 1'b0;
  logic rst;

  sr_cmd_gen_if bus ();

  sr_cmd_gen #(.DB_CYCLES(DB_CFG), .HOLDOFF(H), .CNT_W(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;
  int e = 0;
  bit chk_en = 1'b0;

  // Model state: raw samples and filtered levels per edge since reset release.
  bit raw [2][0:MAXE];
  bit flt [2][0:MAXE];
  int lp;
  bit lp_is_s;
  bit m_s, m_r, m_busy, m_drop, m_q;

  int n_s, n_r, n_drop, n_busy, first_s, first_r, first_drop;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (edge %0d, t=%0t)", name, act, exp, e, $time);
    end
  endtask

  function automatic bit raw_at(int ch, int k);
    return (k < 1) ? 1'b0 : raw[ch][k];
  endfunction

  function automatic bit flt_at(int ch, int k);
    return (k < 1) ? 1'b0 : flt[ch][k];
  endfunction

  // Filtered level after edge k: synchroniser delay, then flip once the last DB samples all disagree.
  function automatic bit next_flt(int ch, int k);
    bit cur;
    bit all_diff;
    cur = flt_at(ch, k - 1);
    if (DB == 0) return raw_at(ch, k - 1);
    all_diff = 1'b1;
    for (int j = 0; j < DB; j++)
      if (raw_at(ch, k - 2 - j) == cur) all_diff = 1'b0;
    return all_diff ? ~cur : cur;
  endfunction

  task automatic model_reset();
    e       = 0;
    lp      = -1000;
    lp_is_s = 1'b0;
    m_s     = 1'b0;
    m_r     = 1'b0;
    m_busy  = 1'b0;
    m_drop  = 1'b0;
    m_q     = 1'b1;
  endtask

  task automatic model_step(input bit sv, input bit rv);
    bit es, er;
    e++;
    raw[0][e] = sv;
    raw[1][e] = rv;
    for (int ch = 0; ch < 2; ch++) flt[ch][e] = next_flt(ch, e);
    es = flt_at(0, e - 2) & ~flt_at(0, e - 3);
    er = flt_at(1, e - 2) & ~flt_at(1, e - 3);
    m_drop = 1'b0;
    if (es || er) begin
      if (e >= lp + H + 2) begin
        lp      = e;
        lp_is_s = !er;
        m_drop  = es && er;
      end else begin
        m_drop = 1'b1;
      end
    end
    m_s    = (lp == e) && lp_is_s;
    m_r    = (lp == e) && !lp_is_s;
    m_busy = (e >= lp) && (e <= lp + H);
    if (e == lp + 1) m_q = lp_is_s;
  endtask

  always @(negedge clk) begin
    if (chk_en && !rst) begin
      chk("s", bus.s, m_s);
      chk("r", bus.r, m_r);
      chk("busy", bus.busy, m_busy);
      chk("drop", bus.drop, m_drop);
      chk("q_pred", bus.q_pred, m_q);
      chk("s_r_exclusive", bus.s & bus.r, 0);
      if (bus.s === 1'b1) begin n_s++; if (first_s < 0) first_s = e; end
      if (bus.r === 1'b1) begin n_r++; if (first_r < 0) first_r = e; end
      if (bus.drop === 1'b1) begin n_drop++; if (first_drop < 0) first_drop = e; end
      if (bus.busy === 1'b1) n_busy++;
    end
  end

  task automatic cyc(input bit sv, input bit rv);
    bus.set_req = sv;
    bus.rst_req = rv;
    @(posedge clk);
    #1;
    model_step(sv, rv);
    chk_en = 1'b1;
  endtask

  task automatic hold(input bit sv, input bit rv, input int n);
    repeat (n) cyc(sv, rv);
  endtask

  task automatic clr_stats();
    n_s = 0; n_r = 0; n_drop = 0; n_busy = 0;
    first_s = -1; first_r = -1; first_drop = -1;
  endtask

  task automatic do_reset(input bit sv, input bit rv);
    chk_en      = 1'b0;
    bus.set_req = sv;
    bus.rst_req = rv;
    rst         = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    model_reset();
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int  nst;
    bit  seen;
    rst         = 1'b1;
    bus.set_req = 1'b0;
    bus.rst_req = 1'b0;
    clr_stats();
    model_reset();

    // Idle after reset: no pulses, q_pred held at 1.
    do_reset(0, 0);
    clr_stats();
    hold(0, 0, 20);
    chk("idle_s_count", n_s, 0);
    chk("idle_r_count", n_r, 0);
    chk("idle_busy_count", n_busy, 0);
    chk("idle_q_pred", bus.q_pred, 1);

    // Held reset request: single r at N+LAT, busy for 1+HOLDOFF cycles, q_pred cleared.
    clr_stats();
    nst = e + 1;
    hold(0, 1, 30);
    hold(0, 0, 20);
    chk("rreq_latency", first_r, nst + LAT);
    chk("rreq_r_count", n_r, 1);
    chk("rreq_busy_len", n_busy, 1 + H);
    chk("rreq_q_pred", bus.q_pred, 0);

    // Three-cycle glitch on set_req: filtered out when debouncing.
    clr_stats();
    hold(1, 0, 3);
    hold(0, 0, 25);
    chk("glitch_s_count", n_s, (DB > 0) ? 0 : 1);
    chk("glitch_drop_count", n_drop, 0);

    // Simultaneous rise: reset wins, set dropped once.
    clr_stats();
    hold(1, 1, 30);
    hold(0, 0, 20);
    chk("both_r_count", n_r, 1);
    chk("both_s_count", n_s, 0);
    chk("both_drop_count", n_drop, 1);

    // Set edge landing inside holdoff is discarded.
    clr_stats();
    nst = e + 1;
    hold(0, 1, 3);
    hold(1, 1, 22);
    hold(0, 0, 25);
    chk("hold_r_latency", first_r, nst + LAT);
    chk("hold_drop_edge", first_drop, nst + 3 + LAT);
    chk("hold_drop_count", n_drop, 1);
    chk("hold_s_count", n_s, 0);

    // Fresh set edge after holdoff: normal latency.
    clr_stats();
    nst = e + 1;
    hold(1, 0, 30);
    hold(0, 0, 10);
    chk("after_s_latency", first_s, nst + LAT);
    chk("after_s_count", n_s, 1);
    chk("after_q_pred", bus.q_pred, 1);

    // Random request traffic with one reset in the middle.
    for (int k = 0; k < 60; k++) begin
      if (k == 30) do_reset(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      hold(1'($urandom_range(0, 1)), ($urandom_range(0, 3) == 0), int'($urandom_range(1, 14)));
    end
    hold(0, 0, 20);

    // Drive q_pred to 0, then abort a set pulse with an asynchronous reset.
    hold(0, 1, 10 + DB);
    hold(0, 0, 20);
    chk("pre_abort_q_pred", bus.q_pred, 0);
    seen = 1'b0;
    for (int k = 0; k < 40 && !seen; k++) begin
      cyc(1, 0);
      if (bus.s === 1'b1) seen = 1'b1;
    end
    chk("abort_s_seen", seen, 1);
    #2;
    chk_en = 1'b0;
    rst    = 1'b1;
    #1;
    chk("abort_s_cleared", bus.s, 0);
    chk("abort_q_pred", bus.q_pred, 1);
    chk("abort_busy", bus.busy, 0);
    do_reset(1, 0);
    clr_stats();
    hold(1, 0, 30);
    hold(0, 0, 10);
    chk("rerun_s_latency", first_s, 1 + LAT);
    chk("rerun_s_count", n_s, 1);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/sr_cmd_gen.md
# sr_cmd_gen

Command front-end for the SR flip-flop stage. Takes two raw, asynchronous request levels (set and reset, e.g. pushbuttons), synchronises and debounces them, and detects their rising edges. It emits one-cycle `s` / `r` pulses that are guaranteed mutually exclusive, so the downstream SR flip-flop never sees the forbidden {1,1} input. It also keeps a shadow copy of the flip-flop's output state for status and checking.

## Interface
- `DB_CYCLES`, default 4: consecutive stable cycles required before a filtered level changes; range 1..2^CNT_W-1.
- `HOLDOFF`, default 8: lockout cycles after each emitted pulse; range 1..2^CNT_W-1.
- `CNT_W`, default 8: width of the debounce and holdoff counters.
- `clk` input 1: single clock, rising edge.
- `rst` input 1: reset, asynchronous and active-high; all state clears immediately on assertion.
- `set_req` input 1: raw set request level, asynchronous to `clk`.
- `rst_req` input 1: raw reset request level, asynchronous to `clk`.
- `s` output 1: set pulse to the SR flip-flop; registered.
- `r` output 1: reset pulse to the SR flip-flop; registered.
- `q_pred` output 1: predicted flip-flop `q`; registered.
- `busy` output 1: high while the FSM is in PULSE or HOLDOFF.
- `drop` output 1: one-cycle flag, high when a request edge is discarded.

## Operation
- Input path, per channel:
  - 2-flop synchroniser, reset to 0.
  - Debounce filter: the filtered level takes the synchronised value only after that value has differed from the current filtered level for DB_CYCLES consecutive cycles. The counter restarts whenever the synchronised value bounces back.
  - A rising edge of the filtered level produces a one-cycle request event.
- FSM states: IDLE, PULSE_S, PULSE_R, HOLDOFF.
  - IDLE, reset event present → PULSE_R. Reset has priority when both events arrive in the same cycle; the set event is then dropped and `drop` pulses.
  - IDLE, set event only → PULSE_S.
  - PULSE_S / PULSE_R → HOLDOFF after exactly one cycle. The holdoff counter loads HOLDOFF-1.
  - HOLDOFF → IDLE when the counter reaches 0.
- Outputs:
  - `s` = 1 only in PULSE_S; `r` = 1 only in PULSE_R. Never both.
  - `q_pred`: set to 1 at the clock edge ending PULSE_S and cleared to 0 at the edge ending PULSE_R, i.e. on the same edge the flip-flop updates.
- Events arriving in PULSE_* or HOLDOFF are discarded, not queued; `drop` pulses for one cycle.
- Reset values: `s`=0, `r`=0, `busy`=0, `drop`=0, `q_pred`=1 (matches the flip-flop power-up `q`=1). FSM = IDLE; counters, synchronisers and filtered levels all 0.
- Reset mid-operation aborts any pulse or holdoff immediately. A request held high through reset deassertion is seen as a fresh rising edge and yields exactly one pulse after normal latency.

## Timing
- Let N be the first cycle in which raw `set_req` is sampled high and stays high.
  - With debounce compiled in: `s` is high in cycle N+3+DB_CYCLES. Without debounce: cycle N+3.
  - The same latency applies to `rst_req` / `r`.
- Pulse width: exactly 1 cycle.
- Minimum spacing between two output pulses: 1+HOLDOFF cycles.
- `busy` is high from the pulse cycle through the last HOLDOFF cycle.
- `drop` is registered and asserts in the cycle the discarded event would have been accepted.

## Configuration
- `SR_CMD_DEBOUNCE_EN` defined: the debounce filter is instantiated per channel, and `DB_CYCLES` applies.
- Not defined: the filtered level equals the synchroniser output directly, and `DB_CYCLES` is ignored. Edge detection, FSM and holdoff behaviour are unchanged.

## Structure
- Shared package `sr_cmd_pkg`:
  - FSM state encoding (IDLE=2'd0, PULSE_S=2'd1, PULSE_R=2'd2, HOLDOFF=2'd3).
  - Default constants for DB_CYCLES, HOLDOFF and CNT_W.
- Sub-module `sr_debounce` (synchroniser + filter + rising-edge detect, one instance per channel), parameterised by DB_CYCLES and CNT_W.
- Top level holds the FSM, the holdoff counter and `q_pred`.

## Test plan
- Reset release with both inputs at 0 → `s`=`r`=0, `q_pred`=1, `busy`=0 for 20 cycles.
- `rst_req` high and held, DB_CYCLES=4 (debounce on) → `r` high for exactly 1 cycle at N+7; `q_pred` becomes 0 the next cycle; `busy` high for 9 cycles.
- `set_req` glitches high for 3 cycles, DB_CYCLES=4 → no `s` pulse, `drop`=0.
- Both requests rise in the same cycle → single `r` pulse, no `s`, `drop` pulses once; `s`&`r` never 1 together (assertion over the whole run).
- `set_req` edge arrives 2 cycles into HOLDOFF → discarded, `drop`=1 for one cycle, no `s`; after holdoff, a new `set_req` edge gives `s` with normal latency.
- `rst` asserted during PULSE_S → `s` drops within the same cycle (asynchronous clear), `q_pred`=1, FSM = IDLE; `set_req` still held at deassertion → exactly one `s` pulse at normal latency.
